// File: rtl/led_blink_driver.sv
// Turns single-cycle event pulses into visible, evenly spaced LED blinks.
// Requests arriving mid-blink are queued up to MAX_PENDING; extras are dropped and flagged.
module led_blink_driver #(
   parameter int ON_CYCLES   = 20,
   parameter int OFF_CYCLES  = 20,
   parameter int MAX_PENDING = 3,
   parameter int PEND_W      = $clog2(MAX_PENDING + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pulse_in,
   output logic              led_out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0]  ON_LAST   = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0]  OFF_LAST  = CNT_W'(OFF_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(MAX_PENDING);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_stateNext;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cntNext;
   logic              r_led;
   logic              w_ledNext;
   logic [PEND_W-1:0] r_pending;
   logic [PEND_W-1:0] w_pendingNext;
   logic              r_overflow;
   logic              w_overflowNext;
   logic              w_slotFree;
   logic              w_start;

   // A new blink may begin from IDLE or on the last cycle of the dark gap.
   assign w_slotFree = (r_state == IDLE) || ((r_state == OFF) && (r_cnt == OFF_LAST));
   assign w_start    = w_slotFree && ((r_pending != '0) || pulse_in);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_led      <= 1'b0;
         r_pending  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_cnt      <= w_cntNext;
         r_led      <= w_ledNext;
         r_pending  <= w_pendingNext;
         r_overflow <= w_overflowNext;
      end
   end

   always_comb begin
      w_stateNext    = r_state;
      w_cntNext      = r_cnt;
      w_ledNext      = 1'b0;
      w_pendingNext  = r_pending;
      w_overflowNext = 1'b0;

      case (r_state)
         ON: begin
            if (r_cnt == ON_LAST) begin
               w_stateNext = OFF;
               w_cntNext   = '0;
               w_ledNext   = 1'b0;
            end else begin
               w_cntNext = r_cnt + CNT_W'(1);
               w_ledNext = 1'b1;
            end
         end
         OFF: begin
            if (r_cnt == OFF_LAST) begin
               w_stateNext = IDLE;
               w_cntNext   = '0;
            end else begin
               w_cntNext = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_cntNext   = '0;
         end
      endcase

      // Starting overrides the phase logic; a queued request is served before a fresh one.
      if (w_start) begin
         w_stateNext = ON;
         w_cntNext   = '0;
         w_ledNext   = 1'b1;
         if ((r_pending != '0) && !pulse_in) begin
            w_pendingNext = r_pending - PEND_W'(1);
         end
      end else if (pulse_in) begin
         if (r_pending == PEND_FULL) begin
            w_overflowNext = 1'b1;
         end else begin
            w_pendingNext = r_pending + PEND_W'(1);
         end
      end
   end

   assign led_out  = r_led;
   assign busy     = (r_state != IDLE);
   assign pending  = r_pending;
   assign overflow = r_overflow;

endmodule
